// File: rtl/pokey_audio_divider_ctl.sv
// POKEY audio divider sequencer: 64/15 kHz prescaler, per-channel clock select, 8/16-bit dividers.
// Optional POKEY_DIVIDER_DEBUG_EN exposes the four channel counters on dbg_cnt.
module pokey_audio_divider_ctl #(
  parameter int PRE64_DIV = 28,
  parameter int PRE15_DIV = 114
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enp,
  input  logic [7:0] audctl,
  input  logic [7:0] audf1,
  input  logic [7:0] audf2,
  input  logic [7:0] audf3,
  input  logic [7:0] audf4,
  input  logic       stimer,
  output logic [3:0] tick
`ifdef POKEY_DIVIDER_DEBUG_EN
  ,
  output logic [67:0] dbg_cnt
`endif
);

  logic [6:0]  pre_q, pre_d;
  logic [6:0]  div_m1;
  logic        base;
  logic [16:0] cnt_q [4];
  logic [16:0] cnt_d [4];
  logic [1:0]  join_q, join_d;
  logic [1:0]  fast_q, fast_d;
  logic [3:0]  tick_q, tick_d;
  logic [7:0]  audf [4];

  assign audf[0] = audf1;
  assign audf[1] = audf2;
  assign audf[2] = audf3;
  assign audf[3] = audf4;

  // Divisor is not latched: a count already past the new terminal value runs on to 127 and wraps.
  assign div_m1 = audctl[0] ? 7'(PRE15_DIV - 1) : 7'(PRE64_DIV - 1);
  assign base   = enp && (pre_q == div_m1);

  always_comb begin
    logic        join_new;
    logic        fast_new;
    logic        ev_lo;
    logic        reload;
    logic [1:0]  lo;
    logic [1:0]  hi;
    logic [1:0]  ctl;
    logic [16:0] hv;
    logic [16:0] lv;
    logic [16:0] jv;

    pre_d    = pre_q;
    tick_d   = '0;
    join_d   = join_q;
    fast_d   = fast_q;
    join_new = 1'b0;
    fast_new = 1'b0;
    ev_lo    = 1'b0;
    reload   = 1'b0;
    lo       = '0;
    hi       = '0;
    ctl      = '0;
    hv       = '0;
    lv       = '0;
    jv       = '0;
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];

    if (enp) pre_d = base ? 7'd0 : pre_q + 7'd1;

    // Pair p covers channels 2p+1 (low) and 2p+2 (high); join/clock mode is latched at the pair reload.
    for (int p = 0; p < 2; p++) begin
      lo       = 2'(2 * p);
      hi       = 2'(2 * p + 1);
      join_new = (p == 0) ? audctl[4] : audctl[3];
      fast_new = (p == 0) ? audctl[6] : audctl[5];
      ev_lo    = fast_q[p] ? enp : base;
      ctl      = join_q[p] ? hi : lo;
      hv       = {9'd0, audf[hi]};
      lv       = {8'd0, {1'b0, audf[lo]} + (fast_new ? 9'd3 : 9'd0)};
      jv       = {1'b0, audf[hi], audf[lo]} + (fast_new ? 17'd6 : 17'd0);
      reload   = 1'b0;

      if (!join_q[p] && base && !stimer) begin
        if (cnt_q[hi] == 17'd0) begin
          tick_d[hi] = 1'b1;
          cnt_d[hi]  = hv;
        end else begin
          cnt_d[hi] = cnt_q[hi] - 17'd1;
        end
      end

      if (stimer) begin
        reload = 1'b1;
      end else if (ev_lo) begin
        if (cnt_q[ctl] == 17'd0) begin
          tick_d[ctl] = 1'b1;
          reload      = 1'b1;
        end else begin
          cnt_d[ctl] = cnt_q[ctl] - 17'd1;
        end
      end

      // An unjoined high channel keeps its own phase unless stimer or a split from joined mode reloads it.
      if (reload) begin
        join_d[p] = join_new;
        fast_d[p] = fast_new;
        if (join_new) begin
          cnt_d[lo] = '0;
          cnt_d[hi] = jv;
        end else begin
          cnt_d[lo] = lv;
          if (stimer || join_q[p]) cnt_d[hi] = hv;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= '0;
      join_q <= '0;
      fast_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      join_q <= join_d;
      fast_q <= fast_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign tick = tick_q;

`ifdef POKEY_DIVIDER_DEBUG_EN
  assign dbg_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
